cla_seq_adder: RTL and testbench

- Multi-precision add/subtract sequencer built around one shared 4-bit CLA slice.
- Accepts WIDTH-bit operands over a valid/ready handshake.
- Runs the operands through the CLA one nibble per clock, LSB first, chaining the carry through a register.
- Presents sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits between a requester and the 4-bit adder datapath, so wide adds reuse the single registered CLA instead of a wide adder.

---
 rtl/cla_seq_pkg.sv | 8 +
 rtl/cla_seq_adder_cla4.sv | 18 +
 rtl/cla_seq_adder.sv | 80 ++++++++
 tb/tb_cla_seq_adder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state encoding and sizing helpers for the nibble-serial adder
package cla_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int SLICE_W = 4;
  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction
endpackage

// File: rtl/cla_seq_adder_cla4.sv
// cla_seq_adder_cla4: combinational 4-bit carry-lookahead slice, C_out[3] is the nibble carry-out
module cla_seq_adder_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin,
  output logic [3:0] sum,
  output logic [3:0] C_out
);
  logic [3:0] w_g, w_p;
  assign w_g = a & b;
  assign w_p = a ^ b;
  assign C_out[0] = w_g[0] | (w_p[0] & Cin);
  assign C_out[1] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & Cin);
  assign C_out[2] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & Cin);
  assign C_out[3] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                  | (&w_p[3:0] & Cin);
  assign sum = w_p ^ {C_out[2:0], Cin};
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit add/subtract run one nibble per clock through a shared 4-bit CLA
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int IW = idx_w(NIB);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [IW-1:0] r_idx;
  logic r_carry, r_cout, r_ovf, w_last;
  logic [SLICE_W-1:0] w_s, w_c;
  cla_seq_adder_cla4 u_cla (
    .a    (r_a[r_idx*SLICE_W +: SLICE_W]),
    .b    (r_b[r_idx*SLICE_W +: SLICE_W]),
    .Cin  (r_carry),
    .sum  (w_s),
    .C_out(w_c)
  );
  assign w_last    = r_idx == IW'(NIB - 1);
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // operands are pre-conditioned at capture so RUN is a plain add for both ops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a     <= op_a;
      r_b     <= op_sub ? ~op_b : op_b;
      r_carry <= op_sub | cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*SLICE_W +: SLICE_W] <= w_s;
      r_carry <= w_c[3];
      if (w_last) begin
        r_cout <= w_c[3];
        r_ovf  <= w_c[3] ^ w_c[2];
      end else r_idx <= r_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed vectors with a result scoreboard for cla_seq_adder
module tb_cla_seq_adder;
  localparam int W = 16;
  logic clk = 0, rst = 1, in_valid = 0, op_sub = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] op_a = '0, op_b = '0, sum;
  typedef struct packed {logic [W-1:0] s; logic c; logic v;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  cla_seq_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
    .op_sub(op_sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got sum 0x%0h with no pending request", sum);
      end else begin
        mon_e = q.pop_front();
        check("sum", sum, mon_e.s);
        check("cout", cout, mon_e.c);
        check("ovf", ovf, mon_e.v);
      end
    end
  end
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                      input logic [W-1:0] es, input logic ec, input logic ev, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1; op_a = a; op_b = b; op_sub = s; cin = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end else if (push) q.push_back(exp_t'{es, ec, ev});
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic lat(input string tag);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready, k == 6);
      check({tag, "_out_valid"}, out_valid, k == 5);
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk);
    #1 rst = 0;
    send(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 1);
    lat("lat1");
    send(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    send(16'h0000, 16'h0000, 0, 1, 16'h0001, 0, 0, 1);
    send(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 1);
    send(16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0, 1);
    send(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, 1);
    send(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 1);
    send(16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1, 1);
    drain();
    out_ready = 0;
    send(16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    in_valid = 1; op_a = 16'h0F0F; op_b = 16'h0101; op_sub = 0; cin = 0;
    repeat (3) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", sum, 16'h3333);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    q.push_back(exp_t'{16'h1010, 1'b0, 1'b0});
    @(posedge clk);
    #1 in_valid = 0;
    lat("lat_bp");
    send(16'h1234, 16'h1111, 0, 0, 16'h0000, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    check("abort_in_ready", in_ready, 1);
    send(16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 1);
    lat("lat_rst");
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
